instruction_decode: RTL
=======================

// Module: instruction_decode
// PURPOSE
//  ID stage of the 5-stage RV32I pipeline, directly downstream of instruction fetch.
//  - Consumes the IF/ID instruction and PC, and decodes opcode/funct3/funct7.
//  - Generates immediates and reads the 32x32 register file (write port driven by WB).
//  - Detects load-use hazards and registers everything into the ID/EX pipeline register.
// PARAMETERS
//  DATA_WIDTH   32   datapath width; taken from riscv_definitions
//  REG_COUNT    32   architectural registers; x0 is hardwired to zero
// PORTS
//  clk             in   1   main clock
//  rst_n           in   1   reset; synchronous, active-low
//  clk_en          in   1   pipeline advance enable; 0 = hold all state
//  i_flush         in   1   branch/jump taken; kill the instruction in ID
//  i_if_inst       in   32  instruction from IF/ID
//  i_if_pc         in   32  PC of i_if_inst
//  i_ex_mem_read   in   1   instruction in EX is a load
//  i_ex_rd_addr    in   5   destination of the instruction in EX
//  i_wb_reg_write  in   1   WB register write enable
//  i_wb_rd_addr    in   5   WB destination register
//  i_wb_rd_data    in   32  WB write data
//  o_hazard_stall  out  1   combinational load-use stall request to IF (freeze PC and IF/ID)
//  o_id_pc         out  32  ID/EX: PC
//  o_id_rs1_data   out  32  ID/EX: rs1 value
//  o_id_rs2_data   out  32  ID/EX: rs2 value
//  o_id_imm        out  32  ID/EX: sign-extended immediate
//  o_id_rs1_addr   out  5   ID/EX: rs1 index (for forwarding)
//  o_id_rs2_addr   out  5   ID/EX: rs2 index (for forwarding)
//  o_id_rd_addr    out  5   ID/EX: rd index
//  o_id_ctrl       out  ctrl_t  ID/EX control bundle:
//                       alu_op, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump, funct3
//  o_id_illegal    out  1   ID/EX: unsupported opcode
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all ID/EX outputs are 0 (ctrl = NOP bubble); all registers x1..x31 = 0.
//    Reset wins over clk_en and i_flush.
//  - Latency: decode and register read are combinational; results appear at ID/EX outputs 1 cycle later.
//  - Decode: R, I, S, B, U and J formats.
//    - Immediates are sign-extended from inst[31].
//    - U-type immediate = {inst[31:12],12'b0}.
//    - B/J immediates have LSB = 0.
//  - Illegal opcode: ctrl = bubble and o_id_illegal = 1.
//    i_if_inst == 0 (the IF flush value) decodes as a bubble with o_id_illegal = 0.
//  - Hazard: o_hazard_stall = i_ex_mem_read && i_ex_rd_addr != 0 &&
//    (i_ex_rd_addr == rs1 || (uses_rs2 && i_ex_rd_addr == rs2)).
//    uses_rs2 is true for R, S and B formats only.
//  - ID/EX update priority, each taken only when clk_en = 1:
//    1. rst_n = 0: reset values.
//    2. i_flush: bubble, illegal = 0.
//    3. o_hazard_stall: bubble inserted; data fields don't-care.
//    4. Otherwise: decoded values.
//  - ID/EX when clk_en = 0: every ID/EX output holds.
//  - Register file:
//    - Write on clk edge when i_wb_reg_write && i_wb_rd_addr != 0.
//    - Writes are independent of clk_en, so WB data is never lost during stalls.
//    - Writes to x0 are ignored; reads of x0 return 0.
//  - Simultaneous WB write and ID read of the same register: see CONFIGURATION.
// CONFIGURATION
//  - Macro RF_WRITE_BYPASS_EN defined:
//    - A read whose address equals i_wb_rd_addr (non-zero, write enabled) returns i_wb_rd_data in the same cycle.
//  - Macro not defined:
//    - The read returns the old register content.
//    - The hazard unit then also stalls 1 cycle when WB rd matches rs1/rs2 (non-zero).
// STRUCTURE
//  - riscv_definitions package gains:
//    - opcode_t enum (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG).
//    - alu_op_t enum.
//    - ctrl_t packed struct.
//    - CTRL_BUBBLE constant (all zero).
//    - REG_ADDR_WIDTH = 5.
//  - Sub-module register_file:
//    - 2 async read ports, 1 sync write port.
//    - Holds the bypass logic under RF_WRITE_BYPASS_EN.
//  - All decode, immediate and hazard logic lives in instruction_decode.
// TESTING
//  1. ADDI x1,x0,5 (0x00500093), clk_en=1:
//     next cycle imm=5, rd=1, alu_src=1, reg_write=1, rs1_data=0.
//  2. WB writes x0 = 0xFFFFFFFF, then decode ADD x2,x0,x0 (0x00000133):
//     rs1_data = rs2_data = 0.
//  3. i_ex_mem_read=1 with i_ex_rd_addr=1, decode ADD x2,x1,x1 (0x00108133):
//     o_hazard_stall=1 and the next ID/EX is a bubble.
//     Same with LUI x2,1 (0x00001137): stall=0.
//  4. WB writes x3 = 0xDEADBEEF in the same cycle ID reads x3:
//     with RF_WRITE_BYPASS_EN, rs1_data = 0xDEADBEEF next cycle; without it, stall=1 for 1 cycle.
//  5. i_flush=1 with a valid SW at the input: next ID/EX ctrl = bubble.
//     clk_en=0 for 3 cycles: outputs frozen while WB writes still commit.
//  6. rst_n=0 for 1 cycle mid-stream:
//     all ID/EX outputs 0, x5 reads 0 after reset, and a BEQ immediate of -8 decodes as 0xFFFFFFF8.

Source files
------------

// File: rtl/riscv_definitions_pkg.sv
// Shared RV32I definitions: opcodes, ALU ops, the ID/EX control bundle
// and the ID/EX pipeline register layout.
package riscv_definitions;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_op_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic [2:0] funct3;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    ctrl_t                     ctrl;
    logic                      illegal;
  } id_ex_t;

  // funct7[5] selects SUB/SRA; for OP-IMM only the shift uses it
  function automatic alu_op_t alu_from_funct(
    input logic [2:0] f3,
    input logic       f7b5,
    input logic       is_reg
  );
    alu_op_t op;
    unique case (f3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32x32 register file: two async read ports, one sync write port.
// RF_WRITE_BYPASS_EN forwards the same-cycle WB write to the read ports.
module register_file
  import riscv_definitions::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2_addr,
  output logic [DATA_WIDTH-1:0]     o_rs1_data,
  output logic [DATA_WIDTH-1:0]     o_rs2_data,
  input  logic                      i_we,
  input  logic [REG_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]     i_wr_data
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic                  wr_ok;

  assign wr_ok = i_we && (i_wr_addr != '0);

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (wr_ok && i_wr_addr == REG_ADDR_WIDTH'(i))
        regs_d[i] = i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++)
        regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_port(
    input logic [REG_ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] v;
    v = (a == '0) ? '0 : regs_q[a];
`ifdef RF_WRITE_BYPASS_EN
    if (wr_ok && a == i_wr_addr)
      v = i_wr_data;
`endif
    return v;
  endfunction

  assign o_rs1_data = rd_port(i_rs1_addr);
  assign o_rs2_data = rd_port(i_rs2_addr);

endmodule

// File: rtl/instruction_decode.sv
// RV32I ID stage: decode, immediates, register read, hazard detect, ID/EX.
// Optional macro RF_WRITE_BYPASS_EN: same-cycle WB-to-ID register bypass.
module instruction_decode
  import riscv_definitions::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_en,
  input  logic                      i_flush,
  input  logic [DATA_WIDTH-1:0]     i_if_inst,
  input  logic [DATA_WIDTH-1:0]     i_if_pc,
  input  logic                      i_ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd_addr,
  input  logic                      i_wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_wb_rd_data,
  output logic                      o_hazard_stall,
  output logic [DATA_WIDTH-1:0]     o_id_pc,
  output logic [DATA_WIDTH-1:0]     o_id_rs1_data,
  output logic [DATA_WIDTH-1:0]     o_id_rs2_data,
  output logic [DATA_WIDTH-1:0]     o_id_imm,
  output logic [REG_ADDR_WIDTH-1:0] o_id_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] o_id_rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0] o_id_rd_addr,
  output ctrl_t                     o_id_ctrl,
  output logic                      o_id_illegal
);

  logic [6:0]                opc;
  logic [2:0]                f3;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic [DATA_WIDTH-1:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [DATA_WIDTH-1:0]     rs1_data, rs2_data;
  ctrl_t                     ctrl;
  logic [DATA_WIDTH-1:0]     imm;
  logic                      illegal;
  logic                      uses_rs2;
  logic                      load_use;
  logic                      wb_hz;
  id_ex_t                    dec;
  id_ex_t                    id_ex_d, id_ex_q;

  assign opc = i_if_inst[6:0];
  assign f3  = i_if_inst[14:12];
  assign rs1 = i_if_inst[19:15];
  assign rs2 = i_if_inst[24:20];
  assign rd  = i_if_inst[11:7];

  assign imm_i = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
  assign imm_s = {{20{i_if_inst[31]}}, i_if_inst[31:25],
                  i_if_inst[11:7]};
  assign imm_b = {{19{i_if_inst[31]}}, i_if_inst[31], i_if_inst[7],
                  i_if_inst[30:25], i_if_inst[11:8], 1'b0};
  assign imm_u = {i_if_inst[31:12], 12'b0};
  assign imm_j = {{11{i_if_inst[31]}}, i_if_inst[31],
                  i_if_inst[19:12], i_if_inst[20],
                  i_if_inst[30:21], 1'b0};

  register_file u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rs1_addr (rs1),
    .i_rs2_addr (rs2),
    .o_rs1_data (rs1_data),
    .o_rs2_data (rs2_data),
    .i_we       (i_wb_reg_write),
    .i_wr_addr  (i_wb_rd_addr),
    .i_wr_data  (i_wb_rd_data)
  );

  always_comb begin
    ctrl     = CTRL_BUBBLE;
    imm      = '0;
    illegal  = 1'b0;
    uses_rs2 = 1'b0;
    case (opc)
      OP_LUI: begin
        imm            = imm_u;
        ctrl.alu_op    = ALU_LUI;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        imm            = imm_u;
        ctrl.alu_op    = ALU_AUIPC;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_JAL: begin
        imm            = imm_j;
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_JALR: begin
        imm            = imm_i;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.funct3    = f3;
      end
      OP_BRANCH: begin
        imm         = imm_b;
        uses_rs2    = 1'b1;
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
        ctrl.funct3 = f3;
      end
      OP_LOAD: begin
        imm             = imm_i;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.funct3     = f3;
      end
      OP_STORE: begin
        imm            = imm_s;
        uses_rs2       = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.funct3    = f3;
      end
      OP_IMM: begin
        imm            = imm_i;
        ctrl.alu_op    = alu_from_funct(f3, i_if_inst[30], 1'b0);
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.funct3    = f3;
      end
      OP_REG: begin
        uses_rs2       = 1'b1;
        ctrl.alu_op    = alu_from_funct(f3, i_if_inst[30], 1'b1);
        ctrl.reg_write = 1'b1;
        ctrl.funct3    = f3;
      end
      default: begin
        // the all-zero IF flush word is a plain bubble, not an error
        illegal = (i_if_inst != '0);
      end
    endcase
  end

  assign load_use = i_ex_mem_read && (i_ex_rd_addr != '0) &&
                    ((i_ex_rd_addr == rs1) ||
                     (uses_rs2 && i_ex_rd_addr == rs2));

`ifdef RF_WRITE_BYPASS_EN
  assign wb_hz = 1'b0;
`else
  // without bypass, wait one cycle for the WB write to land
  assign wb_hz = i_wb_reg_write && (i_wb_rd_addr != '0) &&
                 ((i_wb_rd_addr == rs1) ||
                  (uses_rs2 && i_wb_rd_addr == rs2));
`endif

  assign o_hazard_stall = load_use || wb_hz;

  always_comb begin
    dec          = '0;
    dec.pc       = i_if_pc;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.imm      = imm;
    dec.rs1_addr = rs1;
    dec.rs2_addr = rs2;
    dec.rd_addr  = rd;
    dec.ctrl     = ctrl;
    dec.illegal  = illegal;

    id_ex_d = id_ex_q;
    if (clk_en) begin
      id_ex_d = dec;
      if (i_flush || o_hazard_stall) begin
        id_ex_d.ctrl    = CTRL_BUBBLE;
        id_ex_d.illegal = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) id_ex_q <= '0;
    else        id_ex_q <= id_ex_d;
  end

  assign o_id_pc       = id_ex_q.pc;
  assign o_id_rs1_data = id_ex_q.rs1_data;
  assign o_id_rs2_data = id_ex_q.rs2_data;
  assign o_id_imm      = id_ex_q.imm;
  assign o_id_rs1_addr = id_ex_q.rs1_addr;
  assign o_id_rs2_addr = id_ex_q.rs2_addr;
  assign o_id_rd_addr  = id_ex_q.rd_addr;
  assign o_id_ctrl     = id_ex_q.ctrl;
  assign o_id_illegal  = id_ex_q.illegal;

endmodule
